// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: default width, skid-buffer states and
// the result+flags entry carried through the output stage.
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic                 n;
        logic                 z;
        logic                 c;
        logic                 v;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z derivation for an ALU result; C/V pass through.
// Zero latency, no flow control. Results narrower than ALU_WIDTH are zero-extended into the entry.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] result,
    input  logic             carry,
    input  logic             overflow,
    output alu_entry_t       entry
);

    always_comb begin
        entry                    = '0;
        entry.result[WIDTH-1:0]  = result;
        entry.n                  = result[WIDTH-1];
        entry.z                  = (result == '0);
        entry.c                  = carry;
        entry.v                  = overflow;
    end

endmodule

// File: rtl/alu_result_skid.sv
// Registered ALU result+flags stage with a 2-entry skid buffer; 1-cycle latency.
// in_ready_o is decoded from the state register only, so consumer stalls never reach the producer combinationally.
module alu_result_skid
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] result_i,
    input  logic             carry_i,
    input  logic             overflow_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             negative_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic [1:0]       count_o
);

    skid_state_e state_q, state_d;
    alu_entry_t  main_q, skid_q;
    alu_entry_t  in_entry;
    logic        push, pop;
    logic        load_main, main_from_skid, load_skid;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result   (result_i),
        .carry    (carry_i),
        .overflow (overflow_i),
        .entry    (in_entry)
    );

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (push && pop) begin
                    load_main = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Ready is low here, so only a pop can move the state.
                if (pop) begin
                    state_d        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_entry;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = (state_q != FULL);
    assign result_o    = main_q.result[WIDTH-1:0];
    assign negative_o  = main_q.n;
    assign zero_o      = main_q.z;
    assign carry_o     = main_q.c;
    assign overflow_o  = main_q.v;

    always_comb begin
        count_o = 2'd0;
        unique case (state_q)
            EMPTY:   count_o = 2'd0;
            ONE:     count_o = 2'd1;
            FULL:    count_o = 2'd2;
            default: count_o = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_alu_result_skid.sv
// Scenario bench for alu_result_skid: per-feature tasks compare DUT outputs against an
// occupancy model and a queue of expected entries pushed when the bench drives a push.
module tb_alu_result_skid;

    typedef struct {
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] result_in;
    logic        carry_in;
    logic        ovf_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result_out;
    logic        neg_out;
    logic        zero_out;
    logic        carry_out;
    logic        ovf_out;
    logic [1:0]  count_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_exp[$];
    int   model_cnt = 0;
    bit   last_push = 0;

    alu_result_skid #(.WIDTH(64)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .result_i    (result_in),
        .carry_i     (carry_in),
        .overflow_i  (ovf_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result_out),
        .negative_o  (neg_out),
        .zero_o      (zero_out),
        .carry_o     (carry_out),
        .overflow_o  (ovf_out),
        .count_o     (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t make_exp(logic [63:0] r, logic c, logic v);
        exp_t e;
        e.res = r;
        e.n   = r[63];
        e.z   = (r == 64'd0);
        e.c   = c;
        e.v   = v;
        return e;
    endfunction

    // Advances one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        bit   push_m, pop_m;
        exp_t tmp;
        push_m = in_valid && (model_cnt < 2);
        pop_m  = out_ready && (model_cnt > 0);
        if (pop_m) tmp = q_exp.pop_front();
        if (push_m) q_exp.push_back(make_exp(result_in, carry_in, ovf_in));
        model_cnt = model_cnt + int'(push_m) - int'(pop_m);
        last_push = push_m;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q_exp.delete();
        model_cnt = 0;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        result_in = 64'hDEAD_BEEF_0000_0001;
        carry_in  = 1'b1;
        ovf_in    = 1'b1;
        do_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (count_out !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_out); end
        n_checks++; if (result_out !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_out); end
        n_checks++; if ({neg_out, zero_out, carry_out, ovf_out} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {neg_out, zero_out, carry_out, ovf_out});
        end
    endtask

    task automatic test_single();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        result_in = 64'h8000_0000_0000_0000;
        carry_in  = 1'b1;
        ovf_in    = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_checks++; if (result_out !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL single_result: got %h want 8000000000000000", result_out); end
        n_checks++; if ({neg_out, zero_out, carry_out, ovf_out} !== 4'b1011) begin
            n_fail++; $display("FAIL single_flags: got %b want 1011", {neg_out, zero_out, carry_out, ovf_out});
        end
        n_checks++; if (count_out !== 2'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count_out); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got valid %b want 0", out_valid); end
    endtask

    task automatic test_fill();
        logic [63:0] popped[$];
        logic [63:0] want[3];
        bit          done;
        want[0] = 64'd0; want[1] = 64'd5; want[2] = 64'd7;
        out_ready = 1'b0;
        carry_in  = 1'b0;
        ovf_in    = 1'b0;
        in_valid  = 1'b1;
        result_in = 64'd0;
        tick();
        result_in = 64'd5;
        tick();
        n_checks++; if (count_out !== 2'd2) begin n_fail++; $display("FAIL fill_count: got %0d want 2", count_out); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", in_ready); end
        n_checks++; if (zero_out !== 1'b1) begin n_fail++; $display("FAIL fill_head_z: got %b want 1", zero_out); end
        result_in = 64'd7;
        tick();
        tick();
        n_checks++; if (count_out !== 2'd2) begin n_fail++; $display("FAIL fill_blocked_count: got %0d want 2", count_out); end
        n_checks++; if (result_out !== 64'd0) begin n_fail++; $display("FAIL fill_blocked_head: got %h want 0", result_out); end
        out_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            if (model_cnt > 0) begin
                n_checks++; if (result_out !== q_exp[0].res) begin
                    n_fail++; $display("FAIL fill_pop_result: got %h want %h", result_out, q_exp[0].res);
                end
                popped.push_back(result_out);
            end
            tick();
            if (last_push) in_valid = 1'b0;
            done = !in_valid && (model_cnt == 0);
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL fill_timeout: drain not complete, model_cnt %0d", model_cnt); end
        n_checks++; if (popped.size() != 3) begin
            n_fail++; $display("FAIL fill_pop_count: got %0d want 3", popped.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++; if (popped[k] !== want[k]) begin
                    n_fail++; $display("FAIL fill_order[%0d]: got %h want %h", k, popped[k], want[k]);
                end
            end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got valid %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        carry_in  = 1'b0;
        ovf_in    = 1'b0;
        for (int i = 1; i <= 101; i++) begin
            in_valid  = (i <= 100);
            result_in = 64'(i);
            if (model_cnt > 0) begin
                n_checks++; if (out_valid !== 1'b1 || result_out !== q_exp[0].res) begin
                    n_fail++; $display("FAIL stream_head: got valid %b res %h want valid 1 res %h", out_valid, result_out, q_exp[0].res);
                end
                n_checks++; if (count_out !== 2'd1) begin n_fail++; $display("FAIL stream_count: got %0d want 1", count_out); end
                n_checks++; if (result_out !== 64'(i - 1)) begin n_fail++; $display("FAIL stream_latency: got %h want %h", result_out, 64'(i - 1)); end
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || q_exp.size() != 0) begin
            n_fail++; $display("FAIL stream_drain: got valid %b queue %0d want 0/0", out_valid, q_exp.size());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int pushed = 0;
        int cyc    = 0;
        int sel;
        last_push = 1'b1;
        in_valid  = 1'b0;
        while ((pushed < 1000 || model_cnt > 0) && cyc < 20000) begin
            if (pushed >= 1000) begin
                in_valid = 1'b0;
            end else if (!in_valid || last_push) begin
                in_valid = ($urandom_range(0, 1) == 1);
                sel = $urandom_range(0, 7);
                if (sel == 0)      result_in = 64'd0;
                else if (sel == 1) result_in = 64'h8000_0000_0000_0000;
                else               result_in = {$urandom, $urandom};
                carry_in = 1'($urandom_range(0, 1));
                ovf_in   = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 1) == 1);
            n_checks++; if (in_ready !== (model_cnt != 2) || out_valid !== (model_cnt != 0) || count_out !== 2'(model_cnt)) begin
                n_fail++; $display("FAIL rand_state: got rdy %b vld %b cnt %0d want model_cnt %0d", in_ready, out_valid, count_out, model_cnt);
            end
            if (out_ready && model_cnt > 0) begin
                n_checks++; if (result_out !== q_exp[0].res || neg_out !== q_exp[0].n || zero_out !== q_exp[0].z
                                || carry_out !== q_exp[0].c || ovf_out !== q_exp[0].v) begin
                    n_fail++; $display("FAIL rand_pop: got %h nzcv %b want %h nzcv %b", result_out,
                                       {neg_out, zero_out, carry_out, ovf_out}, q_exp[0].res,
                                       {q_exp[0].n, q_exp[0].z, q_exp[0].c, q_exp[0].v});
                end
            end
            tick();
            if (last_push) pushed++;
            cyc++;
        end
        n_checks++; if (pushed != 1000 || model_cnt != 0) begin
            n_fail++; $display("FAIL rand_timeout: pushed %0d remaining %0d want 1000/0", pushed, model_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        carry_in  = 1'b1;
        ovf_in    = 1'b0;
        result_in = 64'h11;
        tick();
        result_in = 64'h22;
        tick();
        n_checks++; if (count_out !== 2'd2) begin n_fail++; $display("FAIL rfull_pre_count: got %0d want 2", count_out); end
        result_in = 64'h33;
        out_ready = 1'b1;
        do_reset();
        in_valid = 1'b0;
        n_checks++; if (count_out !== 2'd0) begin n_fail++; $display("FAIL rfull_count: got %0d want 0", count_out); end
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rfull_handshake: got vld %b rdy %b want 0 1", out_valid, in_ready);
        end
        n_checks++; if (result_out !== 64'd0 || {neg_out, zero_out, carry_out, ovf_out} !== 4'b0000) begin
            n_fail++; $display("FAIL rfull_outputs: got %h %b want 0 0000", result_out, {neg_out, zero_out, carry_out, ovf_out});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rfull_stale[%0d]: got valid %b want 0", k, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        result_in = 64'd0;
        carry_in  = 1'b0;
        ovf_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_reset_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
